mem_line_responder: RTL and testbench

- Memory-side end of the core's line-granular memory port.
- Accepts one L1D or L1I line request at a time from the core's I/D arbiter, services it against an internal line-wide RAM after a fixed latency, and returns a single-cycle response that echoes the request tag and opcode.
- Used as the backing memory in simulation and FPGA builds, directly beneath the core wrapper.

---
 rtl/mem_line_responder_pkg.sv | 31 +++
 rtl/mem_line_responder_if.sv | 33 +++
 rtl/mem_line_responder_line_ram.sv | 27 ++
 rtl/mem_line_responder.sv | 145 ++++++++++++++
 tb/tb_mem_line_responder.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_line_responder_pkg.sv
// Shared definitions for the memory-side line responder.
// Contents: bus widths, the two legal opcodes, the responder FSM state type,
// the captured-request struct and an opcode legality helper.
package mem_line_responder_pkg;

  localparam int unsigned M_WIDTH            = 32;
  localparam int unsigned LG_MEM_TAG_ENTRIES = 4;

  localparam logic [4:0] MEM_LW = 5'd4;
  localparam logic [4:0] MEM_SW = 5'd7;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } mem_rsp_state_t;

  // Store data is not kept here: it goes straight into the RAM on the capture edge.
  typedef struct packed {
    logic [M_WIDTH-1:0]            addr;
    logic [4:0]                    opcode;
    logic [LG_MEM_TAG_ENTRIES-1:0] tag;
    logic                          insn;
  } mem_line_req_t;

  // Instruction-side stores are illegal: L1I never writes memory.
  function automatic logic opcode_ok(input logic [4:0] op, input logic insn);
    return (op == MEM_LW) || ((op == MEM_SW) && !insn);
  endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// Line-granular memory port between the core's I/D arbiter and the backing memory.
// master: core side (drives mem_req_*, receives ack and mem_rsp_*).
// slave : memory side (receives mem_req_*, drives ack and mem_rsp_*).
interface mem_line_responder_if #(
  parameter int unsigned CL_BITS = 128
);
  import mem_line_responder_pkg::*;

  logic                          mem_req_valid;
  logic [M_WIDTH-1:0]            mem_req_addr;
  logic [CL_BITS-1:0]            mem_req_store_data;
  logic [LG_MEM_TAG_ENTRIES-1:0] mem_req_tag;
  logic [4:0]                    mem_req_opcode;
  logic                          mem_req_insn;
  logic                          mem_req_ack;
  logic                          mem_rsp_valid;
  logic [CL_BITS-1:0]            mem_rsp_load_data;
  logic [LG_MEM_TAG_ENTRIES-1:0] mem_rsp_tag;
  logic [4:0]                    mem_rsp_opcode;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
    output mem_req_insn,
    input  mem_req_ack, mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag, mem_rsp_opcode
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
    input  mem_req_insn,
    output mem_req_ack, mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag, mem_rsp_opcode
  );

endinterface

// File: rtl/mem_line_responder_line_ram.sv
// Single-port synchronous line RAM, 2^LG_LINES x CL_BITS.
// Ports: clk; we/wdata write on the edge; re loads rdata on the edge, otherwise
// rdata holds; addr shared by both. Contents are not reset.
module mem_line_responder_line_ram #(
  parameter int unsigned LG_LINES = 10,
  parameter int unsigned CL_BITS  = 128
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [LG_LINES-1:0] addr,
  input  logic [CL_BITS-1:0]  wdata,
  output logic [CL_BITS-1:0]  rdata
);

  logic [CL_BITS-1:0] mem [2**LG_LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side end of the core's line port: captures one request at a time,
// services it against the internal line RAM after LATENCY cycles and returns a
// one-cycle response echoing tag and opcode.
// Ports: clk, reset (synchronous, active low), mem (slave modport of
// mem_line_responder_if), bad_opcode (sticky illegal-request flag).
// Build option: MEM_LINE_RESPONDER_JITTER_EN adds 0..7 cycles of LFSR-driven
// extra latency per request.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int unsigned LG_LINES = 10,
  parameter int unsigned CL_BITS  = 128,
  parameter int unsigned LATENCY  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_line_responder_if.slave  mem,
  output logic                 bad_opcode
);

  localparam int unsigned LG_CL_BYTES = $clog2(CL_BITS / 8);
  // Wide enough for LATENCY-1 plus the maximum jitter of 7.
  localparam int unsigned CntW = 9;

  mem_rsp_state_t                state_q;
  logic [CntW-1:0]               cnt_q;
  logic [CntW-1:0]               cnt_load;
  mem_line_req_t                 req_q;
  logic                          ack_q;
  logic                          rsp_valid_q;
  logic [LG_MEM_TAG_ENTRIES-1:0] rsp_tag_q;
  logic [4:0]                    rsp_opcode_q;
  logic                          rsp_sel_ram_q;
  logic                          bad_q;

  logic                          capture;
  logic [LG_LINES-1:0]           cap_idx;
  logic [LG_LINES-1:0]           req_idx;
  logic [LG_LINES-1:0]           ram_addr;
  logic                          ram_we;
  logic                          ram_re;
  logic [CL_BITS-1:0]            ram_rdata;

  assign capture = (state_q == StIdle) && mem.mem_req_valid;
  assign cap_idx = mem.mem_req_addr[LG_CL_BYTES +: LG_LINES];
  assign req_idx = req_q.addr[LG_CL_BYTES +: LG_LINES];

  // Gating with reset keeps a write from landing on an edge that also resets the FSM.
  assign ram_addr = (state_q == StIdle) ? cap_idx : req_idx;
  assign ram_we   = reset && capture && (mem.mem_req_opcode == MEM_SW) && !mem.mem_req_insn;
  assign ram_re   = reset && (state_q == StBusy) && (cnt_q == CntW'(1)) &&
                    (req_q.opcode == MEM_LW);

`ifdef MEM_LINE_RESPONDER_JITTER_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign cnt_load = CntW'(LATENCY - 1) + CntW'(lfsr_q[2:0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else if (capture) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  assign cnt_load = CntW'(LATENCY - 1);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      req_q         <= '0;
      ack_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_tag_q     <= '0;
      rsp_opcode_q  <= '0;
      rsp_sel_ram_q <= 1'b0;
      bad_q         <= 1'b0;
    end else begin
      ack_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (mem.mem_req_valid) begin
            req_q.addr   <= mem.mem_req_addr;
            req_q.opcode <= mem.mem_req_opcode;
            req_q.tag    <= mem.mem_req_tag;
            req_q.insn   <= mem.mem_req_insn;
            cnt_q        <= cnt_load;
            ack_q        <= 1'b1;
            state_q      <= StBusy;
            if (!opcode_ok(mem.mem_req_opcode, mem.mem_req_insn)) begin
              bad_q <= 1'b1;
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - CntW'(1);
          // cnt_q==1 means the count reaches 0 on this edge.
          if (cnt_q == CntW'(1)) begin
            state_q       <= StResp;
            rsp_valid_q   <= 1'b1;
            rsp_tag_q     <= req_q.tag;
            rsp_opcode_q  <= req_q.opcode;
            rsp_sel_ram_q <= (req_q.opcode == MEM_LW);
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  mem_line_responder_line_ram #(
    .LG_LINES (LG_LINES),
    .CL_BITS  (CL_BITS)
  ) u_line_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (mem.mem_req_store_data),
    .rdata (ram_rdata)
  );

  // ram_rdata only changes on a load read, so response data holds between responses.
  assign mem.mem_req_ack       = ack_q;
  assign mem.mem_rsp_valid     = rsp_valid_q;
  assign mem.mem_rsp_load_data = rsp_sel_ram_q ? ram_rdata : '0;
  assign mem.mem_rsp_tag       = rsp_tag_q;
  assign mem.mem_rsp_opcode    = rsp_opcode_q;
  assign bad_opcode            = bad_q;

  logic unused_bits;
  assign unused_bits = ^{req_q.addr, req_q.insn, mem.mem_req_addr};

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed self-checking bench for mem_line_responder (LG_LINES=10, CL_BITS=128,
// LATENCY=4). Define MEM_LINE_RESPONDER_JITTER_EN to exercise the jitter build.
module tb_mem_line_responder;
  import mem_line_responder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bad_opcode;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] pre0 = 128'hA5A5A5A5_00000000_5A5A5A5A_00000000;
  logic [127:0] pre3 = 128'h0123456789ABCDEF_0123456789ABCDEF;
  logic [127:0] pre5 = 128'h55555555_66666666_77777777_88888888;
  logic [127:0] ones = '1;
  logic [127:0] zero = '0;

  mem_line_responder_if #(.CL_BITS(128)) bus ();

  mem_line_responder #(
    .LG_LINES (10),
    .CL_BITS  (128),
    .LATENCY  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (bus),
    .bad_opcode (bad_opcode)
  );

  always #5 clk = ~clk;

  function automatic bit lat_ok(input int lat);
`ifdef MEM_LINE_RESPONDER_JITTER_EN
    return (lat >= 4) && (lat <= 11);
`else
    return lat == 4;
`endif
  endfunction

  // Presents a request in the cycle after the next rising edge (cycle T) and
  // reports ack/response cycle offsets relative to T plus the response fields.
  task automatic issue(input logic [31:0] addr, input logic [4:0] op, input logic [3:0] tag,
                       input logic insn, input logic [127:0] sd,
                       output int ack_lat, output int rsp_lat, output logic [127:0] rd,
                       output logic [3:0] rtag, output logic [4:0] rop);
    @(posedge clk);
    #1;
    bus.mem_req_valid      = 1'b1;
    bus.mem_req_addr       = addr;
    bus.mem_req_opcode     = op;
    bus.mem_req_tag        = tag;
    bus.mem_req_insn       = insn;
    bus.mem_req_store_data = sd;
    ack_lat = -1;
    rsp_lat = -1;
    rd      = '0;
    rtag    = '0;
    rop     = '0;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.mem_req_ack && ack_lat < 0) ack_lat = n;
      if (bus.mem_rsp_valid) begin
        rsp_lat = n;
        rd      = bus.mem_rsp_load_data;
        rtag    = bus.mem_rsp_tag;
        rop     = bus.mem_rsp_opcode;
        bus.mem_req_valid = 1'b0;
        break;
      end
    end
    bus.mem_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.mem_req_ack, bus.mem_rsp_valid, bad_opcode} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 000",
               {bus.mem_req_ack, bus.mem_rsp_valid, bad_opcode});
    end
    n_checks++;
    if ({bus.mem_rsp_load_data, bus.mem_rsp_tag, bus.mem_rsp_opcode} !== 137'd0) begin
      n_fail++;
      $display("FAIL reset_rsp_fields: got %h, expected 0",
               {bus.mem_rsp_load_data, bus.mem_rsp_tag, bus.mem_rsp_opcode});
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_load();
    int al, rl;
    logic [127:0] rd;
    logic [3:0] rt;
    logic [4:0] ro;
    issue(32'h30, MEM_LW, 4'd2, 1'b0, zero, al, rl, rd, rt, ro);
    n_checks++;
    if (al !== 1) begin n_fail++; $display("FAIL load_ack_cycle: got %0d, expected 1", al); end
    n_checks++;
    if (!lat_ok(rl)) begin n_fail++; $display("FAIL load_latency: got %0d, expected 4", rl); end
    n_checks++;
    if (rd !== pre3) begin n_fail++; $display("FAIL load_data: got %h, expected %h", rd, pre3); end
    n_checks++;
    if (rt !== 4'd2) begin n_fail++; $display("FAIL load_tag: got %0d, expected 2", rt); end
    n_checks++;
    if (ro !== MEM_LW) begin n_fail++; $display("FAIL load_opcode: got %0d, expected 4", ro); end
    // One cycle after the response: strobe low, data held.
    @(negedge clk);
    n_checks++;
    if (bus.mem_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rsp_single_cycle: got %b, expected 0", bus.mem_rsp_valid);
    end
    n_checks++;
    if (bus.mem_rsp_load_data !== pre3) begin
      n_fail++; $display("FAIL rsp_data_hold: got %h, expected %h", bus.mem_rsp_load_data, pre3);
    end
  endtask

  task automatic test_back_to_back();
    int al, rl;
    logic [127:0] rd;
    logic [3:0] rt;
    logic [4:0] ro;
    issue(32'h40, MEM_SW, 4'd1, 1'b0, ones, al, rl, rd, rt, ro);
    n_checks++;
    if (!lat_ok(rl)) begin n_fail++; $display("FAIL store_latency: got %0d, expected 4", rl); end
    n_checks++;
    if (rd !== zero) begin n_fail++; $display("FAIL store_data: got %h, expected 0", rd); end
    n_checks++;
    if (ro !== MEM_SW) begin n_fail++; $display("FAIL store_opcode: got %0d, expected 7", ro); end
    n_checks++;
    if (bad_opcode !== 1'b0) begin
      n_fail++; $display("FAIL store_bad_flag: got %b, expected 0", bad_opcode);
    end
    // Presented in the cycle right after the store response.
    issue(32'h40, MEM_LW, 4'd3, 1'b0, zero, al, rl, rd, rt, ro);
    n_checks++;
    if (al !== 1) begin n_fail++; $display("FAIL b2b_ack_cycle: got %0d, expected 1", al); end
    n_checks++;
    if (rd !== ones) begin n_fail++; $display("FAIL b2b_load_data: got %h, expected %h", rd, ones); end
    n_checks++;
    if (rt !== 4'd3) begin n_fail++; $display("FAIL b2b_tag: got %0d, expected 3", rt); end
  endtask

  task automatic test_alias_insn();
    int al, rl;
    logic [127:0] rd;
    logic [3:0] rt;
    logic [4:0] ro;
    // 0x4000 is exactly one RAM size (1024 x 16 bytes) above line 0.
    issue(32'h4000, MEM_LW, 4'd9, 1'b1, zero, al, rl, rd, rt, ro);
    n_checks++;
    if (rd !== pre0) begin n_fail++; $display("FAIL alias_data: got %h, expected %h", rd, pre0); end
    n_checks++;
    if (bad_opcode !== 1'b0) begin
      n_fail++; $display("FAIL insn_load_bad_flag: got %b, expected 0", bad_opcode);
    end
  endtask

  task automatic test_bad_opcode();
    int al, rl;
    logic [127:0] rd;
    logic [3:0] rt;
    logic [4:0] ro;
    issue(32'h30, 5'd9, 4'd5, 1'b0, ones, al, rl, rd, rt, ro);
    n_checks++;
    if (!lat_ok(rl)) begin n_fail++; $display("FAIL bad_latency: got %0d, expected 4", rl); end
    n_checks++;
    if (rd !== zero) begin n_fail++; $display("FAIL bad_data: got %h, expected 0", rd); end
    n_checks++;
    if (ro !== 5'd9 || rt !== 4'd5) begin
      n_fail++; $display("FAIL bad_echo: got op %0d tag %0d, expected op 9 tag 5", ro, rt);
    end
    n_checks++;
    if (bad_opcode !== 1'b1) begin
      n_fail++; $display("FAIL bad_flag_set: got %b, expected 1", bad_opcode);
    end
    issue(32'h30, MEM_LW, 4'd4, 1'b0, zero, al, rl, rd, rt, ro);
    n_checks++;
    if (rd !== pre3) begin n_fail++; $display("FAIL after_bad_data: got %h, expected %h", rd, pre3); end
    n_checks++;
    if (bad_opcode !== 1'b1) begin
      n_fail++; $display("FAIL bad_flag_sticky: got %b, expected 1", bad_opcode);
    end
  endtask

  task automatic test_reset_midflight();
    int al, rl, seen;
    logic [127:0] rd;
    logic [3:0] rt;
    logic [4:0] ro;
    @(posedge clk);
    #1;
    bus.mem_req_valid  = 1'b1;
    bus.mem_req_addr   = 32'h30;
    bus.mem_req_opcode = MEM_LW;
    bus.mem_req_tag    = 4'd6;
    bus.mem_req_insn   = 1'b0;
    @(posedge clk);          // capture edge, end of T
    @(posedge clk);          // start of T+2
    #1;
    reset = 1'b0;
    bus.mem_req_valid = 1'b0;
    @(posedge clk);          // start of T+3
    #1 reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bad_opcode !== 1'b0) begin
      n_fail++; $display("FAIL reset_clears_bad: got %b, expected 0", bad_opcode);
    end
    n_checks++;
    if ({bus.mem_rsp_tag, bus.mem_rsp_opcode} !== 9'd0) begin
      n_fail++; $display("FAIL reset_clears_echo: got %h, expected 0",
                         {bus.mem_rsp_tag, bus.mem_rsp_opcode});
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_rsp_valid) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL no_rsp_after_reset: got %0d, expected 0", seen); end
    issue(32'h30, MEM_LW, 4'd6, 1'b0, zero, al, rl, rd, rt, ro);
    n_checks++;
    if (al !== 1 || !lat_ok(rl)) begin
      n_fail++; $display("FAIL post_reset_timing: got ack %0d rsp %0d, expected 1 and 4", al, rl);
    end
    n_checks++;
    if (rd !== pre3 || rt !== 4'd6) begin
      n_fail++; $display("FAIL post_reset_load: got %h tag %0d, expected %h tag 6", rd, rt, pre3);
    end
  endtask

  task automatic test_store_insn();
    int al, rl;
    logic [127:0] rd;
    logic [3:0] rt;
    logic [4:0] ro;
    issue(32'h50, MEM_SW, 4'd7, 1'b1, ones, al, rl, rd, rt, ro);
    n_checks++;
    if (rd !== zero || bad_opcode !== 1'b1) begin
      n_fail++; $display("FAIL insn_store: got data %h bad %b, expected 0 and 1", rd, bad_opcode);
    end
    issue(32'h50, MEM_LW, 4'd8, 1'b0, zero, al, rl, rd, rt, ro);
    n_checks++;
    if (rd !== pre5) begin
      n_fail++; $display("FAIL insn_store_no_write: got %h, expected %h", rd, pre5);
    end
  endtask

`ifdef MEM_LINE_RESPONDER_JITTER_EN
  task automatic test_jitter();
    int al, rl, lmin, lmax;
    logic [127:0] rd;
    logic [3:0] rt;
    logic [4:0] ro;
    lmin = 1000;
    lmax = -1;
    for (int i = 0; i < 100; i++) begin
      issue(32'h30, MEM_LW, 4'(i), 1'b0, zero, al, rl, rd, rt, ro);
      n_checks++;
      if (rl < 4 || rl > 11 || al !== 1) begin
        n_fail++; $display("FAIL jitter_range: got ack %0d rsp %0d, expected 1 and 4..11", al, rl);
      end
      if (rl < lmin) lmin = rl;
      if (rl > lmax) lmax = rl;
    end
    n_checks++;
    if (lmin == lmax) begin
      n_fail++; $display("FAIL jitter_spread: got single latency %0d, expected >=2 values", lmin);
    end
  endtask
`endif

  initial begin
    bus.mem_req_valid      = 1'b0;
    bus.mem_req_addr       = '0;
    bus.mem_req_store_data = '0;
    bus.mem_req_tag        = '0;
    bus.mem_req_opcode     = '0;
    bus.mem_req_insn       = 1'b0;
    dut.u_line_ram.mem[0] = pre0;
    dut.u_line_ram.mem[3] = pre3;
    dut.u_line_ram.mem[5] = pre5;

    test_reset();
    test_load();
    test_back_to_back();
    test_alias_insn();
    test_bad_opcode();
    test_reset_midflight();
    test_store_insn();
`ifdef MEM_LINE_RESPONDER_JITTER_EN
    test_jitter();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
